// File: rtl/opb_status_bank_pkg.sv
// Shared constants and types for the OPB status register bank.
//  - CTRL bit positions and the word offsets of CTRL/SNAPCNT relative to C_NUM_CH
//  - maximum channel count, OPB bus width, captured-request payload
package opb_status_bank_pkg;

    localparam int unsigned MAX_CH     = 16;
    localparam int unsigned OPB_WIDTH  = 32;
    localparam int unsigned BE_WIDTH   = OPB_WIDTH / 8;
    localparam int unsigned IDX_W      = OPB_WIDTH - 2;

    localparam int unsigned CTRL_SNAP_BIT   = 0;
    localparam int unsigned CTRL_FREEZE_BIT = 1;
    localparam int unsigned CTRL_CLRALL_BIT = 2;

    // Word index offsets added to C_NUM_CH
    localparam int unsigned CTRL_OFS    = 0;
    localparam int unsigned SNAPCNT_OFS = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

    // Transfer captured at the hit cycle, consumed in the ack cycle
    typedef struct packed {
        logic                 rnw;
        logic [IDX_W-1:0]     idx;
        logic [OPB_WIDTH-1:0] wdata;
        logic [OPB_WIDTH-1:0] wmask;
    } opb_req_t;

endpackage

// File: rtl/opb_status_bank_if.sv
// OPB slave-side bus bundle (big-endian bit numbering as on the OPB).
//  master: drives OPB_* request signals, receives Sl_* responses
//  slave : receives OPB_* request signals, drives Sl_* responses
interface opb_status_bank_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    logic [0:AW-1]   OPB_ABus;
    logic [0:DW/8-1] OPB_BE;
    logic [0:DW-1]   OPB_DBus;
    logic            OPB_RNW;
    logic            OPB_select;
    logic            OPB_seqAddr;
    logic [0:DW-1]   Sl_DBus;
    logic            Sl_errAck;
    logic            Sl_retry;
    logic            Sl_toutSup;
    logic            Sl_xferAck;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

endinterface

// File: rtl/opb_status_chan.sv
// One status channel: live (registered input) or sticky (W1C) value plus snapshot copy.
//  clk, rst_n : clock, async active-low reset
//  din        : fabric status word
//  clr        : per-bit clear strobe (sticky mode only)
//  snap       : capture current value into the snapshot register
//  freeze     : select snapshot for read-back
//  rdata_c    : combinational read value
module opb_status_chan #(
    parameter int unsigned W      = 32,
    parameter bit          STICKY = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic [W-1:0] clr,
    input  logic         snap,
    input  logic         freeze,
    output logic [W-1:0] rdata_c
);

    logic [W-1:0] q;
    logic [W-1:0] snap_q;

    // Snapshot takes the pre-update value; in sticky mode a same-cycle set beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            snap_q <= '0;
        end else begin
            q <= STICKY ? ((q & ~clr) | din) : din;
            if (snap) snap_q <= q;
        end
    end

    assign rdata_c = freeze ? snap_q : q;

endmodule

// File: rtl/opb_status_bank.sv
// Multi-channel status register bank on the OPB.
//  OPB_Clk, OPB_Rst_n : clock, async active-low reset
//  opb                : OPB slave bus (request in, response out)
//  user_data_in       : C_NUM_CH status words, channel i at [i*W +: W]
//  user_snap_in       : fabric snapshot strobe
//  snap_pulse_out     : one-cycle pulse after every snapshot
// Word map: 0..N-1 channels, N CTRL, N+1 SNAPCNT (RO), rest of range reads 0.
module opb_status_bank
    import opb_status_bank_pkg::*;
#(
    parameter logic [31:0]       C_BASEADDR    = 32'hFFFF_FFFF,
    parameter logic [31:0]       C_HIGHADDR    = 32'h0000_0000,
    parameter int unsigned       C_OPB_AWIDTH  = 32,
    parameter int unsigned       C_OPB_DWIDTH  = 32,
    parameter int unsigned       C_NUM_CH      = 4,
    parameter int unsigned       C_DATA_WIDTH  = 32,
    parameter logic [MAX_CH-1:0] C_STICKY_MASK = '0,
    parameter string             C_FAMILY      = "virtex5"
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst_n,
    opb_status_bank_if.slave                 opb,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
    input  logic                             user_snap_in,
    output logic                             snap_pulse_out
);

    if (C_OPB_AWIDTH != OPB_WIDTH || C_OPB_DWIDTH != OPB_WIDTH ||
        C_NUM_CH < 1 || C_NUM_CH > MAX_CH ||
        C_DATA_WIDTH < 1 || C_DATA_WIDTH > OPB_WIDTH || C_FAMILY == "") begin : g_bad_cfg
        $error("opb_status_bank: unsupported parameter set");
    end

    ack_state_e           state, state_nxt;
    opb_req_t             req_q, req_nxt;
    logic                 ack_nxt;
    logic [OPB_WIDTH-1:0] rdata_nxt;
    logic [OPB_WIDTH-1:0] addr, addr_ofs, wmask, wd_m, read_word_c;
    logic [BE_WIDTH-1:0]  be;
    logic [IDX_W-1:0]     idx_c;
    logic                 in_range, hit_c, wr_act, ctrl_wr, snap_c, clr_all;
    logic                 freeze;
    logic [OPB_WIDTH-1:0] snap_cnt;
    logic [C_DATA_WIDTH-1:0] ch_rd [C_NUM_CH];

    // Address decode; OPB bit 0 is the MSB, so plain vector copies give LSB-0 order
    assign addr     = opb.OPB_ABus;
    assign addr_ofs = addr - C_BASEADDR;
    assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign idx_c    = addr_ofs[OPB_WIDTH-1:2];
    assign hit_c    = opb.OPB_select && in_range && !opb.Sl_xferAck;

    // BE[0] covers DBus[0:7], i.e. value bits 31:24
    assign be    = opb.OPB_BE;
    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, opb.OPB_seqAddr, addr_ofs[1:0], wd_m};

    // Read mux, evaluated at the hit cycle
    always_comb begin
        read_word_c = '0;
        for (int unsigned i = 0; i < C_NUM_CH; i++) begin
            if (idx_c == IDX_W'(i)) read_word_c = OPB_WIDTH'(ch_rd[i]);
        end
        if (idx_c == IDX_W'(C_NUM_CH + CTRL_OFS)) read_word_c[CTRL_FREEZE_BIT] = freeze;
        if (idx_c == IDX_W'(C_NUM_CH + SNAPCNT_OFS)) read_word_c = snap_cnt;
    end

    // Ack FSM next state: capture request on hit, ack for exactly one cycle
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        rdata_nxt = '0;
        req_nxt   = req_q;
        case (state)
            ST_IDLE: begin
                if (hit_c) begin
                    state_nxt     = ST_ACK;
                    ack_nxt       = 1'b1;
                    req_nxt.rnw   = opb.OPB_RNW;
                    req_nxt.idx   = idx_c;
                    req_nxt.wdata = opb.OPB_DBus;
                    req_nxt.wmask = wmask;
                    if (opb.OPB_RNW) rdata_nxt = read_word_c;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and registered bus outputs
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state          <= ST_IDLE;
            req_q          <= '0;
            opb.Sl_xferAck <= 1'b0;
            opb.Sl_DBus    <= '0;
        end else begin
            state          <= state_nxt;
            req_q          <= req_nxt;
            opb.Sl_xferAck <= ack_nxt;
            opb.Sl_DBus    <= rdata_nxt;
        end
    end

    // Writes take effect at the end of the ack cycle
    assign wr_act  = (state == ST_ACK) && !req_q.rnw;
    assign ctrl_wr = wr_act && (req_q.idx == IDX_W'(C_NUM_CH + CTRL_OFS));
    assign wd_m    = req_q.wdata & req_q.wmask;
    assign snap_c  = (ctrl_wr && wd_m[CTRL_SNAP_BIT]) || user_snap_in;
    assign clr_all = ctrl_wr && wd_m[CTRL_CLRALL_BIT];

    // CTRL freeze bit, snapshot counter and pulse
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            freeze         <= 1'b0;
            snap_cnt       <= '0;
            snap_pulse_out <= 1'b0;
        end else begin
            if (ctrl_wr && req_q.wmask[CTRL_FREEZE_BIT]) freeze <= req_q.wdata[CTRL_FREEZE_BIT];
            if (snap_c) snap_cnt <= snap_cnt + OPB_WIDTH'(1);
            snap_pulse_out <= snap_c;
        end
    end

    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
        logic [C_DATA_WIDTH-1:0] clr_c;

        assign clr_c = clr_all ? '1 :
                       ((wr_act && req_q.idx == IDX_W'(g)) ? wd_m[C_DATA_WIDTH-1:0] : '0);

        opb_status_chan #(
            .W      (C_DATA_WIDTH),
            .STICKY (C_STICKY_MASK[g])
        ) u_chan (
            .clk     (OPB_Clk),
            .rst_n   (OPB_Rst_n),
            .din     (user_data_in[g*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .clr     (clr_c),
            .snap    (snap_c),
            .freeze  (freeze),
            .rdata_c (ch_rd[g])
        );
    end

endmodule
